mipi_hs_burst_scheduler: RTL and testbench
==========================================

// Module: mipi_hs_burst_scheduler
// PURPOSE
//  Shares the single 4-lane HS transmit path between two requesters: video lines and DCS commands.
//  Sits directly upstream of LP_HS_DELAY_CNTRL. Drives that block's hs_en and byte_D3..D0 inputs.
//  Gives each granted burst exactly len words. Enforces a minimum hs_en-low gap so the LP/HS
//  exit-and-entry sequence completes before the next burst.
// PARAMETERS
//  MIN_LP_GAP    16  hs_en-low byte clocks between bursts; legal range 2..65535
//  STARVE_LIMIT  4   consecutive cmd grants before a pending video request must win; legal range 1..255
//  LEN_W         16  width of the burst length fields
// PORTS
//  byte_clk     in   1      byte clock; all logic on its rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  vid_req      in   1      video burst request; held high until vid_gnt
//  vid_len      in   LEN_W  video burst length in 32-bit words; sampled on the grant cycle
//  vid_data     in   32     video word; must be valid in any cycle where vid_rd=1 (FWFT)
//  vid_gnt      out  1      1-cycle grant pulse
//  vid_rd       out  1      video word pop
//  cmd_req      in   1      command burst request; held high until cmd_gnt
//  cmd_len      in   LEN_W  command burst length in 32-bit words
//  cmd_data     in   32     command word; must be valid when cmd_rd=1
//  cmd_gnt      out  1      1-cycle grant pulse
//  cmd_rd       out  1      command word pop
//  hs_en        out  1      HS burst enable to the delay controller
//  byte_D3_out  out  8      lane 3 byte = word[31:24]
//  byte_D2_out  out  8      lane 2 byte = word[23:16]
//  byte_D1_out  out  8      lane 1 byte = word[15:8]
//  byte_D0_out  out  8      lane 0 byte = word[7:0]
//  busy         out  1      high when state != IDLE
// BEHAVIOUR
//  Reset
//   - All outputs go to 0 immediately.
//   - State goes to IDLE; the gap counter is preset to "satisfied"; cmd_streak = 0.
//   - A reset in mid-burst truncates the burst. There is no resume.
//  FSM: IDLE -> BURST -> GAP -> IDLE
//   IDLE: if any request is pending and the gap is satisfied:
//    - arbitrate and latch len (len==0 is treated as 1);
//    - pulse the winner's gnt for one cycle;
//    - go to BURST.
//   BURST:
//    - The winner's rd is high for exactly len cycles, starting in the gnt cycle.
//    - Outputs are registered, so hs_en=1 and byte_D*_out = data at cycle t+1 for rd at cycle t.
//    - After the last rd, go to GAP.
//   GAP:
//    - hs_en=0 and byte_D*_out = 0.
//    - Count low cycles; return to IDLE so that the next hs_en rise occurs exactly MIN_LP_GAP
//      low cycles after the fall.
//    - The gap counter saturates; it never wraps.
//  Arbitration (IDLE only, evaluated in the grant cycle)
//   - Command wins by default.
//   - Video wins if vid_req=1 and either cmd_req=0 or cmd_streak >= STARVE_LIMIT.
//   - A command grant increments cmd_streak (saturating). A video grant clears it.
//  Request rules
//   - req/len changes after gnt are ignored until the next IDLE.
//   - A req dropped before gnt is withdrawn (no grant is issued).
//   - Simultaneous requests in IDLE resolve the same cycle; there is never a dual grant.
//  Invariants
//   - hs_en is never high for two bursts without >= MIN_LP_GAP low cycles between them.
//   - First burst after reset: gnt one cycle after req is seen, with no gap wait.
//   - vid_rd and cmd_rd are never both high. gnt is only ever paired with the matching rd.
//  Latency: req high in IDLE -> gnt on the next edge -> hs_en on the following edge.
// STRUCTURE
//  - Shared header mipi_sched_defs.vh: FSM state encodings (IDLE/BURST/GAP), lane count 4,
//    word width 32, requester IDs (REQ_VID, REQ_CMD).
//  - Sub-module mipi_sched_arb: combinational winner select plus the registered cmd_streak counter
//    (STARVE_LIMIT). The top module holds the FSM, length counter, gap counter and output registers.
// TESTING
//  - Reset: hold reset_n=0 with vid_req=1 -> all outputs 0.
//    Release reset -> vid_gnt pulses 1 cycle later; hs_en rises 1 cycle after vid_gnt.
//  - Single cmd, cmd_len=3, data 0x11223344/0x55667788/0x99AABBCC -> cmd_rd high 3 cycles;
//    hs_en high exactly 3 cycles; D3..D0 = 11,22,33,44 / 55,66,77,88 / 99,AA,BB,CC;
//    the bytes are 0 when hs_en=0.
//  - Back-to-back: cmd_len=1 then video vid_len=2, both requests held -> hs_en low for exactly
//    16 cycles between bursts (MIN_LP_GAP=16).
//  - Starvation: cmd_req and vid_req held continuously, STARVE_LIMIT=4 -> grant order cmd x4,
//    vid, cmd x4, vid.
//  - Edge cases:
//    - vid_len=0 -> treated as 1 word, hs_en high 1 cycle;
//    - vid_len=0xFFFF -> 65535 rd cycles, no counter wrap.
//  - Mid-burst reset at word 5 of 10 -> hs_en=0 asynchronously; the next burst starts clean with
//    the full len; no rd overlap between requesters.

Source files
------------

// File: rtl/mipi_hs_burst_scheduler_pkg.sv
// Shared definitions for the MIPI HS burst scheduler: FSM states, requester
// IDs, lane/word geometry and the burst-length normalisation helper.
package mipi_hs_burst_scheduler_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LANE_W    = WORD_W / NUM_LANES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

    typedef enum logic {
        REQ_VID = 1'b0,
        REQ_CMD = 1'b1
    } req_id_t;

    // A zero-length request still occupies one word slot.
    function automatic logic [31:0] effective_len(input logic [31:0] len);
        return (len == '0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/mipi_hs_burst_scheduler_arb.sv
// Winner select between video and command requesters, with a saturating
// count of consecutive command grants so video cannot be starved.
module mipi_hs_burst_scheduler_arb
    import mipi_hs_burst_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    byte_clk,
    input  logic    reset_n,
    input  logic    vid_req,
    input  logic    cmd_req,
    input  logic    grant,
    output req_id_t winner
);

    localparam logic [7:0] STREAK_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cmd_streak;

    // Command wins by default; video wins when alone or when commands have hogged the link.
    always_comb begin
        winner = REQ_CMD;
        if (vid_req && (!cmd_req || (cmd_streak >= STREAK_LIMIT))) begin
            winner = REQ_VID;
        end
    end

    // Track consecutive command grants; a video grant restarts the count.
    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_streak <= '0;
        end else if (grant) begin
            if (winner == REQ_VID) begin
                cmd_streak <= '0;
            end else if (cmd_streak != '1) begin
                cmd_streak <= cmd_streak + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mipi_hs_burst_scheduler.sv
// Shares the 4-lane HS transmit path between video and command requesters.
// Issues exactly len word pops per granted burst, registers hs_en and lane
// bytes towards the LP/HS delay controller, and enforces a minimum hs_en-low
// gap between bursts.
module mipi_hs_burst_scheduler
    import mipi_hs_burst_scheduler_pkg::*;
#(
    parameter int unsigned MIN_LP_GAP   = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LEN_W        = 16
) (
    input  logic              byte_clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [LEN_W-1:0]  vid_len,
    input  logic [WORD_W-1:0] vid_data,
    output logic              vid_gnt,
    output logic              vid_rd,
    input  logic              cmd_req,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [WORD_W-1:0] cmd_data,
    output logic              cmd_gnt,
    output logic              cmd_rd,
    output logic              hs_en,
    output logic [LANE_W-1:0] byte_D3_out,
    output logic [LANE_W-1:0] byte_D2_out,
    output logic [LANE_W-1:0] byte_D1_out,
    output logic [LANE_W-1:0] byte_D0_out,
    output logic              busy
);

    // gap_q counts hs_en-low cycles already guaranteed at the decision edge;
    // GAP_DONE means the next grant may be issued.
    localparam int unsigned      GAP_W    = $clog2(MIN_LP_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_DONE = GAP_W'(MIN_LP_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_LP_GAP - 1);

    sched_state_t      state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           winner;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              vid_gnt_d, cmd_gnt_d;
    logic              gap_ok, grant;
    logic [LEN_W-1:0]  len_sel;
    logic [WORD_W-1:0] word_q, word_d;

    assign gap_ok  = (gap_q >= GAP_DONE);
    assign grant   = (state_q == ST_IDLE) && (vid_req || cmd_req) && gap_ok;
    assign len_sel = (winner == REQ_VID) ? vid_len : cmd_len;

    mipi_hs_burst_scheduler_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .byte_clk (byte_clk),
        .reset_n  (reset_n),
        .vid_req  (vid_req),
        .cmd_req  (cmd_req),
        .grant    (grant),
        .winner   (winner)
    );

    // Next-state, length and gap counter logic for IDLE -> BURST -> GAP -> IDLE.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rem_d     = rem_q;
        vid_gnt_d = 1'b0;
        cmd_gnt_d = 1'b0;
        gap_d     = (gap_q < GAP_DONE) ? gap_q + 1'b1 : gap_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    owner_d   = winner;
                    rem_d     = LEN_W'(effective_len(32'(len_sel)));
                    vid_gnt_d = (winner == REQ_VID);
                    cmd_gnt_d = (winner == REQ_CMD);
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rem_q == LEN_W'(1)) begin
                    // hs_en is still high for one more cycle, so the gap count starts at 1.
                    gap_d   = GAP_W'(1);
                    state_d = ST_GAP;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, owner, length and gap registers; gap preset to satisfied so the first burst is immediate.
    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= REQ_VID;
            rem_q   <= '0;
            gap_q   <= GAP_DONE;
            vid_gnt <= 1'b0;
            cmd_gnt <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            vid_gnt <= vid_gnt_d;
            cmd_gnt <= cmd_gnt_d;
        end
    end

    assign vid_rd = (state_q == ST_BURST) && (owner_q == REQ_VID);
    assign cmd_rd = (state_q == ST_BURST) && (owner_q == REQ_CMD);
    assign busy   = (state_q != ST_IDLE);

    // Select the word being popped this cycle; zero when no pop.
    always_comb begin
        word_d = '0;
        if (vid_rd) begin
            word_d = vid_data;
        end else if (cmd_rd) begin
            word_d = cmd_data;
        end
    end

    // Registered HS outputs: one cycle behind the pop.
    always_ff @(posedge byte_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_en  <= 1'b0;
            word_q <= '0;
        end else begin
            hs_en  <= vid_rd || cmd_rd;
            word_q <= word_d;
        end
    end

    assign byte_D3_out = word_q[3*LANE_W +: LANE_W];
    assign byte_D2_out = word_q[2*LANE_W +: LANE_W];
    assign byte_D1_out = word_q[1*LANE_W +: LANE_W];
    assign byte_D0_out = word_q[0*LANE_W +: LANE_W];

endmodule

// File: tb/tb_mipi_hs_burst_scheduler.sv
// Directed bench for mipi_hs_burst_scheduler with default parameters
// (MIN_LP_GAP=16, STARVE_LIMIT=4, LEN_W=16).
module tb_mipi_hs_burst_scheduler;

    logic        byte_clk = 1'b0;
    logic        reset_n;
    logic        vid_req, cmd_req;
    logic [15:0] vid_len, cmd_len;
    logic [31:0] vid_data, cmd_data;
    logic        vid_gnt, vid_rd, cmd_gnt, cmd_rd, hs_en, busy;
    logic [7:0]  byte_D3_out, byte_D2_out, byte_D1_out, byte_D0_out;
    logic [31:0] lanes;

    int errors = 0;
    int checks = 0;

    int unsigned vid_pops = 0;
    int unsigned cmd_pops = 0;
    int unsigned cmd_base = 0;
    int unsigned cmd_off;
    logic [31:0] cmd_tab [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};

    mipi_hs_burst_scheduler dut (
        .byte_clk    (byte_clk),
        .reset_n     (reset_n),
        .vid_req     (vid_req),
        .vid_len     (vid_len),
        .vid_data    (vid_data),
        .vid_gnt     (vid_gnt),
        .vid_rd      (vid_rd),
        .cmd_req     (cmd_req),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .cmd_gnt     (cmd_gnt),
        .cmd_rd      (cmd_rd),
        .hs_en       (hs_en),
        .byte_D3_out (byte_D3_out),
        .byte_D2_out (byte_D2_out),
        .byte_D1_out (byte_D1_out),
        .byte_D0_out (byte_D0_out),
        .busy        (busy)
    );

    always #5 byte_clk = ~byte_clk;

    assign lanes = {byte_D3_out, byte_D2_out, byte_D1_out, byte_D0_out};

    // FWFT sources: head word depends on how many words have been popped.
    always @(posedge byte_clk) begin
        if (vid_rd) vid_pops <= vid_pops + 1;
        if (cmd_rd) cmd_pops <= cmd_pops + 1;
    end

    assign vid_data = {16'hA5A5, vid_pops[15:0]};

    always_comb begin
        cmd_off  = cmd_pops - cmd_base;
        cmd_data = (cmd_off < 3) ? cmd_tab[cmd_off] : {16'hC0DE, cmd_pops[15:0]};
    end

    task automatic settle();
        repeat (20) @(negedge byte_clk);
    endtask

    task automatic test_reset();
        int unsigned base;
        reset_n = 1'b0; vid_req = 1'b1; vid_len = 16'd1; cmd_req = 1'b0; cmd_len = 16'd0;
        repeat (3) @(negedge byte_clk);
        checks++;
        if ({vid_gnt, vid_rd, cmd_gnt, cmd_rd, hs_en, busy, lanes} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b%b rd=%b%b hs=%b busy=%b lanes=%h, expected all 0",
                     vid_gnt, cmd_gnt, vid_rd, cmd_rd, hs_en, busy, lanes);
        end
        base = vid_pops;
        reset_n = 1'b1;
        @(negedge byte_clk);
        checks++;
        if ({vid_gnt, vid_rd, cmd_gnt, cmd_rd, hs_en} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_first_gnt: got {vg,vr,cg,cr,hs}=%b, expected 11000",
                     {vid_gnt, vid_rd, cmd_gnt, cmd_rd, hs_en});
        end
        vid_req = 1'b0;
        @(negedge byte_clk);
        checks++;
        if ({vid_gnt, vid_rd, hs_en} !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_hs: got {vg,vr,hs}=%b, expected 001", {vid_gnt, vid_rd, hs_en});
        end
        checks++;
        if (lanes !== {16'hA5A5, base[15:0]}) begin
            errors++;
            $display("FAIL reset_first_word: got %h, expected %h", lanes, {16'hA5A5, base[15:0]});
        end
        @(negedge byte_clk);
        checks++;
        if ({hs_en, lanes} !== 33'd0) begin
            errors++;
            $display("FAIL reset_hs_fall: got hs=%b lanes=%h, expected 0/0", hs_en, lanes);
        end
        settle();
    endtask

    task automatic test_single_cmd();
        logic        exp_gnt  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        exp_rd   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        exp_hs   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] exp_word [6] = '{32'h0, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0, 32'h0};
        cmd_base = cmd_pops;
        cmd_req = 1'b1; cmd_len = 16'd3;
        for (int k = 0; k < 6; k++) begin
            @(negedge byte_clk);
            checks++;
            if ({cmd_gnt, cmd_rd, hs_en, vid_rd} !== {exp_gnt[k], exp_rd[k], exp_hs[k], 1'b0}) begin
                errors++;
                $display("FAIL single_cmd_ctrl[%0d]: got {cg,cr,hs,vr}=%b, expected %b", k,
                         {cmd_gnt, cmd_rd, hs_en, vid_rd}, {exp_gnt[k], exp_rd[k], exp_hs[k], 1'b0});
            end
            checks++;
            if (lanes !== exp_word[k]) begin
                errors++;
                $display("FAIL single_cmd_lanes[%0d]: got D3..D0=%h, expected %h", k, lanes, exp_word[k]);
            end
            if (cmd_gnt) cmd_req = 1'b0;
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int cmd_g = -1, vid_g = -1, fall = -1, rise = -1, hs_cnt = 0, bad = 0;
        logic prev_hs;
        prev_hs = hs_en;
        cmd_req = 1'b1; cmd_len = 16'd1; vid_req = 1'b1; vid_len = 16'd2;
        for (int k = 0; k < 30; k++) begin
            @(negedge byte_clk);
            if ((vid_rd && cmd_rd) || (vid_gnt && cmd_gnt)) bad++;
            if (cmd_gnt) begin cmd_g = k; cmd_req = 1'b0; end
            if (vid_gnt) begin vid_g = k; vid_req = 1'b0; end
            if (hs_en) hs_cnt++;
            if (prev_hs && !hs_en && fall < 0) fall = k;
            if (!prev_hs && hs_en && fall >= 0 && rise < 0) rise = k;
            prev_hs = hs_en;
        end
        checks++;
        if (cmd_g != 0) begin errors++; $display("FAIL b2b_cmd_gnt_cycle: got %0d, expected 0", cmd_g); end
        checks++;
        if (vid_g != 17) begin errors++; $display("FAIL b2b_vid_gnt_cycle: got %0d, expected 17", vid_g); end
        checks++;
        if (rise - fall != 16) begin
            errors++;
            $display("FAIL b2b_gap: got %0d low cycles (fall=%0d rise=%0d), expected 16", rise - fall, fall, rise);
        end
        checks++;
        if (hs_cnt != 3) begin errors++; $display("FAIL b2b_hs_cycles: got %0d, expected 3", hs_cnt); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b_overlap: got %0d, expected 0", bad); end
        settle();
    endtask

    task automatic test_starvation();
        logic exp_vid [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic got_vid [10];
        int   n = 0, dual = 0, unpaired = 0;
        cmd_req = 1'b1; cmd_len = 16'd1; vid_req = 1'b1; vid_len = 16'd1;
        for (int k = 0; k < 400; k++) begin
            @(negedge byte_clk);
            if ((vid_gnt && cmd_gnt) || (vid_rd && cmd_rd)) dual++;
            if ((vid_gnt && !vid_rd) || (cmd_gnt && !cmd_rd)) unpaired++;
            if (vid_gnt || cmd_gnt) begin
                got_vid[n] = vid_gnt;
                n++;
            end
            if (n == 10) break;
        end
        cmd_req = 1'b0; vid_req = 1'b0;
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL starve_timeout: got %0d grants in 400 cycles, expected 10", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_vid[i] !== exp_vid[i]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got vid=%b, expected vid=%b", i, got_vid[i], exp_vid[i]);
            end
        end
        checks++;
        if (dual != 0) begin errors++; $display("FAIL starve_dual: got %0d, expected 0", dual); end
        checks++;
        if (unpaired != 0) begin errors++; $display("FAIL starve_unpaired: got %0d, expected 0", unpaired); end
        settle();
    endtask

    task automatic test_len_zero();
        int unsigned base;
        int          rd_cnt = 0, hs_cnt = 0;
        logic [31:0] word = '0;
        base = vid_pops;
        vid_req = 1'b1; vid_len = 16'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge byte_clk);
            if (vid_gnt) vid_req = 1'b0;
            if (vid_rd) rd_cnt++;
            if (hs_en) begin hs_cnt++; word = lanes; end
        end
        checks++;
        if (rd_cnt != 1) begin errors++; $display("FAIL len0_rd: got %0d, expected 1", rd_cnt); end
        checks++;
        if (hs_cnt != 1) begin errors++; $display("FAIL len0_hs: got %0d, expected 1", hs_cnt); end
        checks++;
        if (word !== {16'hA5A5, base[15:0]}) begin
            errors++;
            $display("FAIL len0_word: got %h, expected %h", word, {16'hA5A5, base[15:0]});
        end
        settle();
    endtask

    task automatic test_len_max();
        int   rd_cnt = 0, hs_cnt = 0;
        logic done = 1'b0;
        vid_req = 1'b1; vid_len = 16'hFFFF;
        for (int k = 0; k < 70000; k++) begin
            @(negedge byte_clk);
            if (vid_gnt) vid_req = 1'b0;
            if (vid_rd) rd_cnt++;
            if (hs_en) hs_cnt++;
            if (hs_cnt > 0 && !hs_en) begin done = 1'b1; break; end
        end
        vid_req = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL lenmax_timeout: got no end of burst, expected end within 70000"); end
        checks++;
        if (rd_cnt != 65535) begin errors++; $display("FAIL lenmax_rd: got %0d, expected 65535", rd_cnt); end
        checks++;
        if (hs_cnt != 65535) begin errors++; $display("FAIL lenmax_hs: got %0d, expected 65535", hs_cnt); end
        settle();
    endtask

    task automatic test_midburst_reset();
        int unsigned base;
        int          rd_cnt = 0, hs_cnt = 0, gnt_at = -1, bad = 0;
        logic [31:0] first_word = '0;
        vid_req = 1'b1; vid_len = 16'd10; cmd_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge byte_clk);
            if (vid_gnt) vid_req = 1'b0;
            if (vid_rd) rd_cnt++;
            if (rd_cnt == 5) break;
        end
        checks++;
        if (hs_en !== 1'b1 || rd_cnt != 5) begin
            errors++;
            $display("FAIL midrst_pre: got hs=%b rd_cnt=%0d, expected 1/5", hs_en, rd_cnt);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({hs_en, vid_rd, vid_gnt, cmd_rd, busy, lanes} !== 37'd0) begin
            errors++;
            $display("FAIL midrst_async: got hs=%b vr=%b vg=%b cr=%b busy=%b lanes=%h, expected all 0",
                     hs_en, vid_rd, vid_gnt, cmd_rd, busy, lanes);
        end
        vid_req = 1'b1; vid_len = 16'd10; cmd_req = 1'b0;
        @(negedge byte_clk);
        base = vid_pops;
        reset_n = 1'b1;
        rd_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge byte_clk);
            if (vid_rd && cmd_rd) bad++;
            if (vid_gnt && gnt_at < 0) begin gnt_at = k; vid_req = 1'b0; end
            if (vid_rd) rd_cnt++;
            if (hs_en) begin
                if (hs_cnt == 0) first_word = lanes;
                hs_cnt++;
            end
        end
        checks++;
        if (gnt_at != 0) begin errors++; $display("FAIL midrst_gnt_cycle: got %0d, expected 0", gnt_at); end
        checks++;
        if (rd_cnt != 10) begin errors++; $display("FAIL midrst_rd: got %0d, expected 10", rd_cnt); end
        checks++;
        if (hs_cnt != 10) begin errors++; $display("FAIL midrst_hs: got %0d, expected 10", hs_cnt); end
        checks++;
        if (first_word !== {16'hA5A5, base[15:0]}) begin
            errors++;
            $display("FAIL midrst_first_word: got %h, expected %h", first_word, {16'hA5A5, base[15:0]});
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midrst_overlap: got %0d, expected 0", bad); end
        settle();
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_back_to_back();
        test_starvation();
        test_len_zero();
        test_len_max();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
